// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator and framebuffer scanout
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  output logic [18:0] mem_addr,
  input  logic [8:0]  mem_rdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [18:0]   ADDR_STEP = 19'(H_ACTIVE);

  logic          tick;
  logic [HW-1:0] hcount, h_next;
  logic [VW-1:0] vcount, v_next;
  logic [18:0]   line_base, base_next, addr_next;
  logic          fs_next;
  logic          act_d, hs_d, vs_d;

  assign VGA_SYNC_N = 1'b0;

  // Next counter position; the row base address steps by H_ACTIVE per line so no multiplier is needed
  always_comb begin
    h_next    = hcount;
    v_next    = vcount;
    base_next = line_base;
    fs_next   = 1'b0;
    if (tick) begin
      if (hcount == H_LAST) begin
        h_next = '0;
        if (vcount == V_LAST) begin
          v_next    = '0;
          base_next = '0;
        end else begin
          v_next    = vcount + VW'(1);
          base_next = line_base + ADDR_STEP;
        end
        fs_next = (v_next == V_ACT);
      end else begin
        h_next = hcount + HW'(1);
      end
    end
    addr_next = ((h_next < H_ACT) && (v_next < V_ACT)) ? (base_next + 19'(h_next)) : '0;
  end

  // Pixel tick, counters and read address; the address moves together with the counters
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      tick        <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      line_base   <= '0;
      mem_addr    <= '0;
      frame_start <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      tick        <= ~tick;
      hcount      <= h_next;
      vcount      <= v_next;
      line_base   <= base_next;
      mem_addr    <= addr_next;
      frame_start <= fs_next;
      VGA_CLK     <= tick;
    end
  end

  // Two-stage video pipeline: stage one delays timing by the RAM latency, stage two registers the DAC outputs
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      act_d       <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
    end else begin
      act_d       <= (hcount < H_ACT) && (vcount < V_ACT);
      hs_d        <= !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
      vs_d        <= !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
      VGA_BLANK_N <= act_d;
      VGA_HS      <= hs_d;
      VGA_VS      <= vs_d;
      VGA_R       <= act_d ? {mem_rdata[8:6], mem_rdata[8:6], mem_rdata[8:7]} : 8'h00;
      VGA_G       <= act_d ? {mem_rdata[5:3], mem_rdata[5:3], mem_rdata[5:4]} : 8'h00;
      VGA_B       <= act_d ? {mem_rdata[2:0], mem_rdata[2:0], mem_rdata[2:1]} : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - bench for vga_scanout
module tb_vga_scanout;

  logic CLOCK_50 = 1'b0;
  logic Reset = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  // small-geometry instance: 15 clocks-per-pixel-line (8 active), 8 lines (4 active)
  logic [18:0] s_addr;
  logic [8:0]  s_rdata;
  logic [7:0]  s_r, s_g, s_b;
  logic        s_hs, s_vs, s_bn, s_sn, s_clk, s_fs;
  // default-geometry instance
  logic [18:0] b_addr;
  logic [8:0]  b_rdata;
  logic [7:0]  b_r, b_g, b_b;
  logic        b_hs, b_vs, b_bn, b_sn, b_clk, b_fs;

  int mode = 0;
  int k = 0;
  int total = 0;
  int bad = 0;

  vga_scanout #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .mem_addr(s_addr), .mem_rdata(s_rdata),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn), .VGA_CLK(s_clk), .frame_start(s_fs)
  );

  vga_scanout dut_big (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .VGA_CLK(b_clk), .frame_start(b_fs)
  );

  function automatic logic [8:0] ram_word(input int m, input logic [18:0] a);
    case (m)
      0:       return 9'h1FF;
      1:       return 9'd7;
      default: return a[8:0] + 9'd37;
    endcase
  endfunction

  function automatic int expand(input int c);
    return 36 * c + c / 2;
  endfunction

  // synchronous RAM models, one clock of read latency
  always @(posedge CLOCK_50) begin
    s_rdata <= ram_word(mode, s_addr);
    b_rdata <= b_addr[8:0];
  end

  // clocks elapsed since the last clock that sampled Reset=1
  always @(posedge CLOCK_50) begin
    if (Reset) k <= 0;
    else k <= k + 1;
  end

  task automatic apply_reset(input int n);
    @(negedge CLOCK_50);
    Reset = 1'b1;
    repeat (n) @(negedge CLOCK_50);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLOCK_50);
    Reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    total++; if (s_addr !== 19'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", s_addr); end
    total++; if ({s_r, s_g, s_b} !== 24'h0) begin bad++; $display("FAIL reset_rgb got %h want 000000", {s_r, s_g, s_b}); end
    total++; if ({s_hs, s_vs, s_bn, s_sn, s_clk, s_fs} !== 6'b110000) begin bad++; $display("FAIL reset_ctl got %b want 110000", {s_hs, s_vs, s_bn, s_sn, s_clk, s_fs}); end
    total++; if (b_addr !== 19'd0) begin bad++; $display("FAIL reset_big_addr got %0d want 0", b_addr); end
    total++; if ({b_hs, b_vs, b_bn, b_sn, b_clk, b_fs, b_r, b_g, b_b} !== {6'b110000, 24'h0}) begin bad++; $display("FAIL reset_big_out got %b want 110000 and zero rgb", {b_hs, b_vs, b_bn, b_sn, b_clk, b_fs}); end
    Reset = 1'b0;
  endtask

  task automatic test_frame(input int m, input int nframes, input bit mid_reset, input string name);
    int p, h, v, q, oh, ov, e_addr, e_r, e_g, e_b, fs_cnt;
    bit e_bn, e_hs, e_vs, e_fs, e_clk;
    logic [8:0] w;
    mode = m;
    apply_reset(2);
    if (mid_reset) begin
      repeat (70) @(negedge CLOCK_50);
      total++; if (s_addr !== 19'd21) begin bad++; $display("FAIL %s pre_reset_addr got %0d want 21", name, s_addr); end
      total++; if (s_bn !== 1'b1) begin bad++; $display("FAIL %s pre_reset_blank got %b want 1", name, s_bn); end
      Reset = 1'b1;
      @(negedge CLOCK_50);
      Reset = 1'b0;
      total++; if (s_addr !== 19'd0) begin bad++; $display("FAIL %s mid_reset_addr got %0d want 0", name, s_addr); end
      total++; if ({s_r, s_g, s_b} !== 24'h0) begin bad++; $display("FAIL %s mid_reset_rgb got %h want 000000", name, {s_r, s_g, s_b}); end
      total++; if ({s_hs, s_vs, s_bn, s_clk, s_fs} !== 5'b11000) begin bad++; $display("FAIL %s mid_reset_ctl got %b want 11000", name, {s_hs, s_vs, s_bn, s_clk, s_fs}); end
    end
    fs_cnt = 0;
    repeat (240 * nframes) begin
      @(negedge CLOCK_50);
      p = k / 2; h = p % 15; v = (p / 15) % 8;
      e_addr = (h < 8 && v < 4) ? v * 8 + h : 0;
      e_bn = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_r = 0; e_g = 0; e_b = 0;
      if (k >= 2) begin
        q = (k - 2) / 2; oh = q % 15; ov = (q / 15) % 8;
        e_bn = (oh < 8 && ov < 4);
        e_hs = !(oh >= 10 && oh <= 12);
        e_vs = !(ov >= 5 && ov <= 6);
        w = ram_word(m, 19'(ov * 8 + oh));
        if (e_bn) begin
          e_r = expand(int'(w[8:6])); e_g = expand(int'(w[5:3])); e_b = expand(int'(w[2:0]));
        end
      end
      e_fs = (k % 2 == 0) && ((k / 2) % 120 == 60);
      e_clk = (k % 2 == 0);
      total++; if (s_addr !== 19'(e_addr)) begin bad++; $display("FAIL %s addr k=%0d got %0d want %0d", name, k, s_addr, e_addr); end
      total++; if (s_bn !== e_bn) begin bad++; $display("FAIL %s blank_n k=%0d got %b want %b", name, k, s_bn, e_bn); end
      total++; if (s_hs !== e_hs) begin bad++; $display("FAIL %s hs k=%0d got %b want %b", name, k, s_hs, e_hs); end
      total++; if (s_vs !== e_vs) begin bad++; $display("FAIL %s vs k=%0d got %b want %b", name, k, s_vs, e_vs); end
      total++; if (s_r !== 8'(e_r)) begin bad++; $display("FAIL %s red k=%0d got %h want %h", name, k, s_r, 8'(e_r)); end
      total++; if (s_g !== 8'(e_g)) begin bad++; $display("FAIL %s green k=%0d got %h want %h", name, k, s_g, 8'(e_g)); end
      total++; if (s_b !== 8'(e_b)) begin bad++; $display("FAIL %s blue k=%0d got %h want %h", name, k, s_b, 8'(e_b)); end
      total++; if (s_fs !== e_fs) begin bad++; $display("FAIL %s frame_start k=%0d got %b want %b", name, k, s_fs, e_fs); end
      total++; if (s_clk !== e_clk) begin bad++; $display("FAIL %s vga_clk k=%0d got %b want %b", name, k, s_clk, e_clk); end
      total++; if (s_sn !== 1'b0) begin bad++; $display("FAIL %s sync_n k=%0d got %b want 0", name, k, s_sn); end
      if (s_fs === 1'b1) fs_cnt++;
    end
    total++; if (fs_cnt != nframes) begin bad++; $display("FAIL %s frame_start_count got %0d want %0d", name, fs_cnt, nframes); end
  endtask

  task automatic test_line_timing();
    int low_cnt, vs_low, fall1, fall2, bn_fall;
    logic prev_hs, prev_bn;
    low_cnt = 0; vs_low = 0; fall1 = -1; fall2 = -1; bn_fall = -1;
    apply_reset(2);
    prev_hs = b_hs; prev_bn = b_bn;
    repeat (3300) begin
      @(negedge CLOCK_50);
      if (b_hs === 1'b0 && k <= 1600) low_cnt++;
      if (b_vs === 1'b0) vs_low++;
      if (prev_hs === 1'b1 && b_hs === 1'b0) begin
        if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
      end
      if (prev_bn === 1'b1 && b_bn === 1'b0 && bn_fall < 0) bn_fall = k;
      prev_hs = b_hs; prev_bn = b_bn;
      if (k == 4) begin
        total++; if ({b_r, b_g, b_b} !== 24'h000024) begin bad++; $display("FAIL big_pix1 got %h want 000024", {b_r, b_g, b_b}); end
      end
      if (k == 12) begin
        total++; if ({b_r, b_g, b_b} !== 24'h0000B6) begin bad++; $display("FAIL big_pix5 got %h want 0000b6", {b_r, b_g, b_b}); end
      end
      if (k == 1202) begin
        total++; if ({b_r, b_g, b_b} !== 24'h246D00) begin bad++; $display("FAIL big_pix600 got %h want 246d00", {b_r, b_g, b_b}); end
      end
      if (k == 1278) begin
        total++; if (b_addr !== 19'd639) begin bad++; $display("FAIL big_addr_639_0 got %0d want 639", b_addr); end
      end
      if (k == 1280) begin
        total++; if (b_addr !== 19'd0) begin bad++; $display("FAIL big_addr_blank got %0d want 0", b_addr); end
      end
      if (k == 1600) begin
        total++; if (b_addr !== 19'd640) begin bad++; $display("FAIL big_addr_0_1 got %0d want 640", b_addr); end
      end
      if (k == 1602) begin
        total++; if (b_addr !== 19'd641) begin bad++; $display("FAIL big_addr_1_1 got %0d want 641", b_addr); end
        total++; if (b_bn !== 1'b1) begin bad++; $display("FAIL big_blank_line1 got %b want 1", b_bn); end
      end
    end
    total++; if (low_cnt != 192) begin bad++; $display("FAIL big_hs_width got %0d want 192", low_cnt); end
    total++; if (fall1 != 1314) begin bad++; $display("FAIL big_hs_first_fall got %0d want 1314", fall1); end
    total++; if (fall2 - fall1 != 1600) begin bad++; $display("FAIL big_hs_period got %0d want 1600", fall2 - fall1); end
    total++; if (bn_fall != 1282) begin bad++; $display("FAIL big_blank_fall got %0d want 1282", bn_fall); end
    total++; if (vs_low != 0) begin bad++; $display("FAIL big_vs_early got %0d want 0", vs_low); end
  endtask

  initial begin
    test_reset();
    test_frame(0, 1, 1'b0, "white");
    test_frame(1, 1, 1'b0, "blue");
    test_frame(2, 2, 1'b0, "addr_data");
    test_frame(2, 1, 1'b1, "mid_reset");
    test_line_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BACK, 33, vertical back porch in lines.
REQ-009 SHALL have port CLOCK_50  in  1  system clock; one clock, all logic on its rising edge.
REQ-010 SHALL have port Reset  in  1  reset; synchronous, active-high.
REQ-011 SHALL have port mem_addr  out  19  framebuffer read address, y*H_ACTIVE+x.
REQ-012 SHALL have port mem_rdata  in  9  framebuffer pixel {R[2:0],G[2:0],B[2:0]}; synchronous RAM, valid 1 clock after mem_addr.
REQ-013 SHALL have ports VGA_R, VGA_G, VGA_B  out  8 each  DAC colour.
REQ-014 SHALL have ports VGA_HS, VGA_VS  out  1 each  syncs, active-low.
REQ-015 SHALL have port VGA_BLANK_N  out  1  low outside the visible area.
REQ-016 SHALL have port VGA_SYNC_N  out  1  constant 0.
REQ-017 SHALL have port VGA_CLK  out  1  pixel clock, CLOCK_50/2.
REQ-018 SHALL have port frame_start  out  1  one-clock pulse at start of vertical blanking; safe window for drawing logic.

Function
REQ-019 SHALL generate pixel tick toggling every CLOCK_50 cycle; h/v counters advance only on tick=1; VGA_CLK = registered tick.
REQ-020 SHALL count hcount 0..H_total-1 (800) and wrap to 0; vcount increments when hcount wraps, wraps at V_total-1 (524) to 0.
REQ-021 SHALL define active region as hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-022 SHALL drive HS low for hcount in [656,751] and VS low for vcount in [490,491] (parameter-derived), high otherwise.
REQ-023 SHALL drive mem_addr = vcount*H_ACTIVE+hcount (registered, computed without a multiplier) in active region, 0 otherwise; range 0..307199.
REQ-024 SHALL pipeline so VGA_R/G/B, VGA_HS, VGA_VS and VGA_BLANK_N for pixel (h,v) update on the same edge, exactly 2 clocks after counters hold (h,v).
REQ-025 SHALL expand 3-bit channel c to 8 bits as {c,c,c[2:1]} (0->0x00, 4->0x92, 7->0xFF).
REQ-026 SHALL force VGA_R/G/B to 0 whenever VGA_BLANK_N is 0.
REQ-027 SHALL pulse frame_start for exactly one clock on the tick where counters move to (h=0, v=V_ACTIVE), once per frame.
REQ-028 SHALL hold counters at wrap values with no skipped or duplicated states at line and frame boundaries.

Reset
REQ-029 SHALL, on any clock with Reset=1, set tick, hcount, vcount, mem_addr, VGA_R/G/B, frame_start, VGA_CLK, VGA_BLANK_N to 0 and VGA_HS, VGA_VS to 1.
REQ-030 SHALL override all activity mid-line/mid-frame on reset; after release, timing restarts from (0,0) identically to power-on.

Verification
REQ-031 SHALL verify: reset then free-run -> HS low 192 clocks every 1600 clocks; VS low 3200 clocks every 840000 clocks.
REQ-032 SHALL verify: RAM model returning 9'h1FF everywhere -> RGB=FF/FF/FF while BLANK_N=1, 00/00/00 while BLANK_N=0; 9'd7 -> R=G=00, B=FF.
REQ-033 SHALL verify: mem_addr = 0 at (0,0), 640 at (0,1), 307199 at (639,479), 0 throughout blanking.
REQ-034 SHALL verify: RAM returning address-derived data -> pixel at output is the word at y*640+x, 2-clock alignment with HS/BLANK_N.
REQ-035 SHALL verify: Reset pulsed 1 clock at (300,200) -> next edge all outputs at reset values; subsequent timing matches scenario REQ-031.
REQ-036 SHALL verify: frame_start high exactly 1 clock per 840000 clocks, coincident with counters entering (0,480).
